// File: rtl/ecs_bit_window.sv
// MSB-aligned bit window between the SOS parser and the Huffman decoder.
// Collects serial ECS bits and exposes a PEEK_W-bit peek with same-edge consume.
module ecs_bit_window #(
    parameter int WIN_W  = 32,
    parameter int PEEK_W = 16,
    parameter int CNT_W  = 6,
    parameter int CON_W  = 5
) (
    input  logic              i_sysclk,
    input  logic              i_arst,
    input  logic              i_start,
    input  logic              i_scan_en,
    input  logic              i_ecs_bit,
    output logic              o_re,
    input  logic [CON_W-1:0]  i_consume,
    output logic [PEEK_W-1:0] o_peek,
    output logic [CNT_W-1:0]  o_level,
    output logic              o_valid,
    output logic              o_err
);

    localparam logic [CON_W-1:0] PEEK_C   = CON_W'(PEEK_W);
    localparam logic [CNT_W-1:0] PEEK_L   = CNT_W'(PEEK_W);
    localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(WIN_W);
    localparam logic [CNT_W-1:0] LVL_TOP  = CNT_W'(WIN_W - 1);
    localparam logic [CNT_W-1:0] LVL_RE   = CNT_W'(WIN_W - 3);

    logic [WIN_W-1:0] win_q, win_d, win_pc;
    logic [CNT_W-1:0] level_q, level_d, lvl_pc, ins_idx;
    logic [CON_W-1:0] cons_eff;
    logic             err_q, err_d, re_q, re_d;
    logic             over, ovf;

    always_comb begin
        over     = (CNT_W'(i_consume) > level_q) || (i_consume > PEEK_C);
        cons_eff = over ? '0 : i_consume;
        lvl_pc   = level_q - CNT_W'(cons_eff);
        win_pc   = win_q << cons_eff;
        ovf      = i_scan_en && (lvl_pc == LVL_FULL);
        ins_idx  = LVL_TOP - lvl_pc;

        win_d   = win_pc;
        level_d = lvl_pc;
        err_d   = err_q | over | ovf;

        // Consume is applied first; the new bit lands just below the surviving bits.
        if (i_scan_en && !ovf) begin
            win_d   = win_pc | (WIN_W'(i_ecs_bit) << ins_idx);
            level_d = lvl_pc + CNT_W'(1);
        end

        // A new scan flushes everything but keeps a same-cycle bit as the first one.
        if (i_start) begin
            win_d          = '0;
            win_d[WIN_W-1] = i_ecs_bit & i_scan_en;
            level_d        = CNT_W'(i_scan_en);
            err_d          = 1'b0;
        end

        re_d = (level_d <= LVL_RE);
    end

    always_ff @(posedge i_sysclk) begin
        if (i_arst) begin
            win_q   <= '0;
            level_q <= '0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            win_q   <= win_d;
            level_q <= level_d;
            err_q   <= err_d;
            re_q    <= re_d;
        end
    end

    assign o_peek  = win_q[WIN_W-1 -: PEEK_W];
    assign o_level = level_q;
    assign o_valid = (level_q >= PEEK_L);
    assign o_err   = err_q;
    assign o_re    = re_q;

endmodule

// File: tb/tb_ecs_bit_window.sv
// Directed bench for ecs_bit_window: a vector table plus hand-written sequences.
module tb_ecs_bit_window;

    logic        clk = 1'b0;
    logic        arst, start, scan_en, ecs_bit, re, valid, err;
    logic [4:0]  consume;
    logic [15:0] peek;
    logic [5:0]  level;

    int tests = 0;
    int fails = 0;

    ecs_bit_window dut (
        .i_sysclk (clk),
        .i_arst   (arst),
        .i_start  (start),
        .i_scan_en(scan_en),
        .i_ecs_bit(ecs_bit),
        .o_re     (re),
        .i_consume(consume),
        .o_peek   (peek),
        .o_level  (level),
        .o_valid  (valid),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        sc;
        logic        bt;
        logic [4:0]  cons;
        logic [5:0]  lvl;
        logic [15:0] pk;
        logic        vld;
        logic        er;
        logic        rr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic st, logic sc, logic bt, logic [4:0] cons,
                                logic [5:0] lvl, logic [15:0] pk, logic vld, logic er, logic rr);
        vec_t v;
        v.name = n; v.st = st; v.sc = sc; v.bt = bt; v.cons = cons;
        v.lvl = lvl; v.pk = pk; v.vld = vld; v.er = er; v.rr = rr;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(logic st, logic sc, logic bt, logic [4:0] cons);
        start = st; scan_en = sc; ecs_bit = bt; consume = cons;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string nm, logic [5:0] lvl, logic [15:0] pk, logic vld, logic er, logic rr);
        chk({nm, ".level"}, 32'(level), 32'(lvl));
        chk({nm, ".peek"},  32'(peek),  32'(pk));
        chk({nm, ".valid"}, 32'(valid), 32'(vld));
        chk({nm, ".err"},   32'(err),   32'(er));
        chk({nm, ".re"},    32'(re),    32'(rr));
    endtask

    initial begin
        arst = 1'b1; start = 1'b0; scan_en = 1'b0; ecs_bit = 1'b0; consume = '0;

        // Fill 1011_0011_1000_1111, then consume/append, plain consumes, error cases, restart.
        vecs.push_back(mk("fill1",  0,1,1, 0,  1, 16'h8000, 0,0,1));
        vecs.push_back(mk("fill2",  0,1,0, 0,  2, 16'h8000, 0,0,1));
        vecs.push_back(mk("fill3",  0,1,1, 0,  3, 16'hA000, 0,0,1));
        vecs.push_back(mk("fill4",  0,1,1, 0,  4, 16'hB000, 0,0,1));
        vecs.push_back(mk("fill5",  0,1,0, 0,  5, 16'hB000, 0,0,1));
        vecs.push_back(mk("fill6",  0,1,0, 0,  6, 16'hB000, 0,0,1));
        vecs.push_back(mk("fill7",  0,1,1, 0,  7, 16'hB200, 0,0,1));
        vecs.push_back(mk("fill8",  0,1,1, 0,  8, 16'hB300, 0,0,1));
        vecs.push_back(mk("fill9",  0,1,1, 0,  9, 16'hB380, 0,0,1));
        vecs.push_back(mk("fill10", 0,1,0, 0, 10, 16'hB380, 0,0,1));
        vecs.push_back(mk("fill11", 0,1,0, 0, 11, 16'hB380, 0,0,1));
        vecs.push_back(mk("fill12", 0,1,0, 0, 12, 16'hB380, 0,0,1));
        vecs.push_back(mk("fill13", 0,1,1, 0, 13, 16'hB388, 0,0,1));
        vecs.push_back(mk("fill14", 0,1,1, 0, 14, 16'hB38C, 0,0,1));
        vecs.push_back(mk("fill15", 0,1,1, 0, 15, 16'hB38E, 0,0,1));
        vecs.push_back(mk("fill16", 0,1,1, 0, 16, 16'hB38F, 1,0,1));
        vecs.push_back(mk("cons4app1", 0,1,1, 4, 13, 16'h38F8, 0,0,1));
        vecs.push_back(mk("cons3",     0,0,0, 3, 10, 16'hC7C0, 0,0,1));
        vecs.push_back(mk("cons6",     0,0,0, 6,  4, 16'hF000, 0,0,1));
        vecs.push_back(mk("overapp",   0,1,0, 5,  5, 16'hF000, 0,1,1));
        vecs.push_back(mk("restart1",  1,1,1, 3,  1, 16'h8000, 0,0,1));
        vecs.push_back(mk("b2",        0,1,0, 0,  2, 16'h8000, 0,0,1));
        vecs.push_back(mk("b3",        0,1,1, 0,  3, 16'hA000, 0,0,1));
        vecs.push_back(mk("b4",        0,1,1, 0,  4, 16'hB000, 0,0,1));
        vecs.push_back(mk("b5",        0,1,0, 0,  5, 16'hB000, 0,0,1));
        vecs.push_back(mk("overcons6", 0,0,0, 6,  5, 16'hB000, 0,1,1));
        vecs.push_back(mk("hold_err",  0,0,0, 0,  5, 16'hB000, 0,1,1));
        vecs.push_back(mk("start0",    1,0,1, 0,  0, 16'h0000, 0,0,1));

        // Reset state, with inputs active so that they must be ignored.
        step(1'b0, 1'b1, 1'b1, 5'd0);
        chk_all("reset", 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        arst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 5'd0);
        chk_all("post_reset", 6'd0, 16'h0000, 1'b0, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].sc, vecs[i].bt, vecs[i].cons);
            chk_all(vecs[i].name, vecs[i].lvl, vecs[i].pk, vecs[i].vld, vecs[i].er, vecs[i].rr);
        end

        // Back-pressure: stream 1,0,1,0,... from empty; o_re drops once the level is 30.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, ~i[0], 5'd0);
            chk($sformatf("bp%0d.level", i + 1), 32'(level), 32'(i + 1));
            chk($sformatf("bp%0d.re", i + 1), 32'(re), 32'((i + 1) <= 29));
        end
        chk_all("full32", 6'd32, 16'hAAAA, 1'b1, 1'b0, 1'b0);

        // Overflow: 33rd bit is dropped.
        step(1'b0, 1'b1, 1'b1, 5'd0);
        chk_all("overflow", 6'd32, 16'hAAAA, 1'b1, 1'b1, 1'b0);

        // Drop to level 20 with err still set, then restart with a same-cycle bit.
        step(1'b0, 1'b0, 1'b0, 5'd12);
        chk_all("cons12", 6'd20, 16'hAAAA, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 5'd0);
        chk_all("restart20", 6'd1, 16'h8000, 1'b0, 1'b0, 1'b1);

        // Consume wider than the peek is rejected even when enough bits are held.
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
        chk_all("refill20", 6'd20, 16'h8000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 5'd17);
        chk_all("cons17", 6'd20, 16'h8000, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 5'd16);
        chk_all("cons16", 6'd4, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Reset mid-scan discards everything.
        arst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 5'd2);
        chk_all("midreset", 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        arst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 5'd0);
        chk_all("midreset_rel", 6'd0, 16'h0000, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
